// File: rtl/auc_wnaf_pkg.sv
// Shared types for the wNAF sequencer: FSM state encoding, phase codes, digit legality check.
package auc_wnaf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_FETCH,
        ST_LOAD,
        ST_DBL,
        ST_ADD,
        ST_CONV,
        ST_FIN
    } state_t;

    localparam logic [1:0] PH_PRE  = 2'b00;
    localparam logic [1:0] PH_DBL  = 2'b01;
    localparam logic [1:0] PH_ADD  = 2'b10;
    localparam logic [1:0] PH_CONV = 2'b11;

    // wNAF digits are zero or odd; a nonzero even magnitude cannot come from a valid recoder.
    function automatic logic dig_illegal(input logic [15:0] mag);
        return (mag != 16'd0) && !mag[0];
    endfunction

endpackage

// File: rtl/auc_wnaf_ctrl_if.sv
// Handshake bundle between the wNAF sequencer, the digit recoder and the point engines.
interface auc_wnaf_ctrl_if #(
    parameter int ADDR   = 5,
    parameter int WINDOW = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              naf_vld;
    logic [WINDOW-1:0] naf_dig;
    logic              naf_last;
    logic              naf_rdy;
    logic              pre_en,  pre_done;
    logic              ld_en,   ld_end;
    logic              dbl_en,  dbl_end;
    logic              add_en,  add_end;
    logic              conv_en, conv_done;
    logic [ADDR-1:0]   paddx, paddy, paddz;
    logic              psign;
    logic              paffine;
    logic [1:0]        phase;
    logic              busy, done, inf, err;
    logic [CNT_W-1:0]  dbl_cnt, add_cnt;

    modport ctrl (
        input  start, abort, naf_vld, naf_dig, naf_last,
               pre_done, ld_end, dbl_end, add_end, conv_done,
        output naf_rdy, pre_en, ld_en, dbl_en, add_en, conv_en,
               paddx, paddy, paddz, psign, paffine, phase,
               busy, done, inf, err, dbl_cnt, add_cnt
    );

    modport host (
        output start, abort, naf_vld, naf_dig, naf_last,
               pre_done, ld_end, dbl_end, add_end, conv_done,
        input  naf_rdy, pre_en, ld_en, dbl_en, add_en, conv_en,
               paddx, paddy, paddz, psign, paffine, phase,
               busy, done, inf, err, dbl_cnt, add_cnt
    );
endinterface

// File: rtl/auc_wnaf_adec.sv
// Digit -> precompute-table address decoder; outputs are captured when a digit is latched.
module auc_wnaf_adec #(
    parameter int ADDR     = 5,
    parameter int WINDOW   = 4,
    parameter int TBL_BASE = 0,
    parameter int ONE_ADDR = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lat,
    input  logic [WINDOW-3:0] j_in,
    input  logic              sign_in,
    output logic [ADDR-1:0]   paddx,
    output logic [ADDR-1:0]   paddy,
    output logic [ADDR-1:0]   paddz,
    output logic              paffine,
    output logic              psign
);
    if (TBL_BASE + 3 * (2 ** (WINDOW - 2) - 1) + 1 >= 2 ** ADDR) begin : g_tbl_overflow
        $error("auc_wnaf_adec: precompute table does not fit in the RAM address space");
    end

    logic [ADDR-1:0] j_a, x_a;

    // kG with k=2j+1 lives at X=base+3j-1; Y and Z follow it.
    assign j_a = ADDR'(j_in);
    assign x_a = ADDR'(TBL_BASE) + j_a + j_a + j_a - ADDR'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paddx   <= '0;
            paddy   <= '0;
            paddz   <= '0;
            paffine <= 1'b0;
            psign   <= 1'b0;
        end else if (lat) begin
            psign <= sign_in;
            if (j_in == '0) begin
                paddx   <= ADDR'(TBL_BASE);
                paddy   <= ADDR'(TBL_BASE) + ADDR'(1);
                paddz   <= ADDR'(ONE_ADDR);
                paffine <= 1'b1;
            end else begin
                paddx   <= x_a;
                paddy   <= x_a + ADDR'(1);
                paddz   <= x_a + ADDR'(2);
                paffine <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/auc_wnaf_ctrl.sv
// wNAF point-multiplication sequencer: precompute, leading load, per-digit double/add, affine conversion.
// Optional macro AUC_WNAF_STAT_EN builds the saturating per-run dbl/add statistics counters.
module auc_wnaf_ctrl
    import auc_wnaf_pkg::*;
#(
    parameter int ADDR     = 5,
    parameter int WINDOW   = 4,
    parameter int TBL_BASE = 0,
    parameter int ONE_ADDR = 19,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    auc_wnaf_ctrl_if.ctrl bus
);
    localparam int MAG_W = WINDOW - 1;

    state_t           state_reg, state_next;
    logic             acc_vld_reg, last_reg, dig_nz_reg;
    logic             pre_en_reg, ld_en_reg, dbl_en_reg, add_en_reg, conv_en_reg;
    logic             done_reg, inf_reg, err_reg;
    logic             pre_en_next, ld_en_next, dbl_en_next, add_en_next, conv_en_next;
    logic             done_next, inf_next, err_next;
    logic [1:0]       phase_reg, phase_next;
    logic [MAG_W-1:0] mag_in;
    logic             take, in_zero, in_illegal, start_acc, entering;

    assign mag_in     = bus.naf_dig[MAG_W-1:0];
    assign in_zero    = (mag_in == '0);
    assign in_illegal = dig_illegal(16'(mag_in));
    assign take       = (state_reg == ST_FETCH) && bus.naf_vld && !bus.abort;
    assign start_acc  = (state_reg == ST_IDLE) && bus.start && !bus.abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            acc_vld_reg <= 1'b0;
            last_reg    <= 1'b0;
            dig_nz_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_acc)
                acc_vld_reg <= 1'b0;
            else if (state_reg == ST_LOAD && bus.ld_end && !bus.abort)
                acc_vld_reg <= 1'b1;
            if (take) begin
                last_reg   <= bus.naf_last;
                dig_nz_reg <= !in_zero;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (bus.start) state_next = ST_PRE;
                ST_PRE:   if (bus.pre_done) state_next = ST_FETCH;
                ST_FETCH: if (bus.naf_vld) begin
                    if (in_illegal)       state_next = ST_IDLE;
                    else if (acc_vld_reg) state_next = ST_DBL;
                    else if (!in_zero)    state_next = ST_LOAD;
                    else if (bus.naf_last) state_next = ST_FIN;
                end
                ST_LOAD:  if (bus.ld_end) state_next = last_reg ? ST_CONV : ST_FETCH;
                ST_DBL:   if (bus.dbl_end) state_next = dig_nz_reg ? ST_ADD :
                                                        (last_reg ? ST_CONV : ST_FETCH);
                ST_ADD:   if (bus.add_end) state_next = last_reg ? ST_CONV : ST_FETCH;
                ST_CONV:  if (bus.conv_done) state_next = ST_FIN;
                ST_FIN:   state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Enables and phase follow the state being entered so they line up with its first cycle.
    always_comb begin
        entering     = (state_next != state_reg);
        pre_en_next  = entering && (state_next == ST_PRE);
        ld_en_next   = entering && (state_next == ST_LOAD);
        dbl_en_next  = entering && (state_next == ST_DBL);
        add_en_next  = entering && (state_next == ST_ADD);
        conv_en_next = entering && (state_next == ST_CONV);
        done_next    = entering && (state_next == ST_FIN);
        inf_next     = done_next && !acc_vld_reg;
        err_next     = take && in_illegal;
        phase_next   = phase_reg;
        case (state_next)
            ST_PRE:          phase_next = PH_PRE;
            ST_DBL:          phase_next = PH_DBL;
            ST_LOAD, ST_ADD: phase_next = PH_ADD;
            ST_CONV:         phase_next = PH_CONV;
            default:         phase_next = phase_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_en_reg  <= 1'b0;
            ld_en_reg   <= 1'b0;
            dbl_en_reg  <= 1'b0;
            add_en_reg  <= 1'b0;
            conv_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            inf_reg     <= 1'b0;
            err_reg     <= 1'b0;
            phase_reg   <= PH_PRE;
        end else begin
            pre_en_reg  <= pre_en_next;
            ld_en_reg   <= ld_en_next;
            dbl_en_reg  <= dbl_en_next;
            add_en_reg  <= add_en_next;
            conv_en_reg <= conv_en_next;
            done_reg    <= done_next;
            inf_reg     <= inf_next;
            err_reg     <= err_next;
            phase_reg   <= phase_next;
        end
    end

    auc_wnaf_adec #(
        .ADDR     (ADDR),
        .WINDOW   (WINDOW),
        .TBL_BASE (TBL_BASE),
        .ONE_ADDR (ONE_ADDR)
    ) u_adec (
        .clk     (clk),
        .rst     (rst),
        .lat     (take),
        .j_in    (bus.naf_dig[MAG_W-1:1]),
        .sign_in (bus.naf_dig[WINDOW-1]),
        .paddx   (bus.paddx),
        .paddy   (bus.paddy),
        .paddz   (bus.paddz),
        .paffine (bus.paffine),
        .psign   (bus.psign)
    );

    assign bus.naf_rdy = take;
    assign bus.busy    = (state_reg != ST_IDLE);
    assign bus.pre_en  = pre_en_reg;
    assign bus.ld_en   = ld_en_reg;
    assign bus.dbl_en  = dbl_en_reg;
    assign bus.add_en  = add_en_reg;
    assign bus.conv_en = conv_en_reg;
    assign bus.done    = done_reg;
    assign bus.inf     = inf_reg;
    assign bus.err     = err_reg;
    assign bus.phase   = phase_reg;

`ifdef AUC_WNAF_STAT_EN
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;
    assign cnt_inc = {add_en_reg, dbl_en_reg};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt_reg <= '0;
            else if (start_acc)
                cnt_reg <= '0;
            else if (cnt_inc[gi] && !(&cnt_reg))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
        assign cnt_val[gi] = cnt_reg;
    end

    assign bus.dbl_cnt = cnt_val[0];
    assign bus.add_cnt = cnt_val[1];
`else
    assign bus.dbl_cnt = '0;
    assign bus.add_cnt = '0;
`endif

endmodule

// File: tb/tb_auc_wnaf_ctrl.sv
// Directed self-checking bench for auc_wnaf_ctrl with 3-cycle engine models.
module tb_auc_wnaf_ctrl;
    localparam int ADDR = 5, WINDOW = 4, CNT_W = 16;
`ifdef AUC_WNAF_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    auc_wnaf_ctrl_if #(.ADDR(ADDR), .WINDOW(WINDOW), .CNT_W(CNT_W)) bus ();

    auc_wnaf_ctrl #(
        .ADDR(ADDR), .WINDOW(WINDOW), .TBL_BASE(0), .ONE_ADDR(19), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // engine models: end pulse 3 cycles after enable, or forced by hand
    logic       eng_auto;
    logic [4:0] man_v, en_v, end_v;
    assign en_v = {bus.conv_en, bus.add_en, bus.dbl_en, bus.ld_en, bus.pre_en};
    genvar gi;
    for (gi = 0; gi < 5; gi++) begin : g_eng
        logic [2:0] sh;
        always @(posedge clk or negedge rst)
            if (!rst) sh <= '0;
            else      sh <= {sh[1:0], en_v[gi]};
        assign end_v[gi] = (eng_auto && sh[2]) || man_v[gi];
    end
    assign bus.pre_done  = end_v[0];
    assign bus.ld_end    = end_v[1];
    assign bus.dbl_end   = end_v[2];
    assign bus.add_end   = end_v[3];
    assign bus.conv_done = end_v[4];

    int n_chk = 0, n_fail = 0;
    int rdy_n = 0, pre_n = 0, ld_n = 0, dbl_n = 0, add_n = 0, conv_n = 0, done_n = 0, err_n = 0;
    int dbl_at_ld = 0;
    logic [ADDR-1:0] ld_x, ld_y, ld_z, add_x, add_y, add_z;
    logic ld_s, ld_aff, add_s, add_aff, done_inf;
    logic [1:0] ld_ph, dbl_ph, conv_ph, pre_ph;

    always @(negedge clk) begin
        if (bus.naf_rdy) rdy_n++;
        if (bus.pre_en) begin pre_n++; pre_ph = bus.phase; end
        if (bus.ld_en) begin
            ld_n++; dbl_at_ld = dbl_n; ld_ph = bus.phase;
            ld_x = bus.paddx; ld_y = bus.paddy; ld_z = bus.paddz;
            ld_s = bus.psign; ld_aff = bus.paffine;
        end
        if (bus.dbl_en) begin dbl_n++; dbl_ph = bus.phase; end
        if (bus.add_en) begin
            add_n++;
            add_x = bus.paddx; add_y = bus.paddy; add_z = bus.paddz;
            add_s = bus.psign; add_aff = bus.paffine;
        end
        if (bus.conv_en) begin conv_n++; conv_ph = bus.phase; end
        if (bus.done) begin done_n++; done_inf = bus.inf; end
        if (bus.err) err_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [3:0] d, input logic l);
        bit ok = 0;
        bus.naf_vld = 1'b1; bus.naf_dig = d; bus.naf_last = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.naf_rdy) begin ok = 1; break; end
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL feed_rdy: naf_rdy=0 for digit %h, required 1 within 100 cycles", d); end
        tick(1);
        bus.naf_vld = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done || bus.err) begin seen = 1; break; end
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL %s_timeout: no done/err, required within 300 cycles", nm); end
        tick(1);
    endtask

    task automatic test_reset();
        n_chk++;
        if ({bus.busy, bus.done, bus.err, bus.inf, bus.naf_rdy, bus.pre_en, bus.ld_en, bus.dbl_en,
             bus.add_en, bus.conv_en, bus.psign, bus.paffine} !== 12'd0) begin
            n_fail++; $display("FAIL rst_flags: got %b required 0", {bus.busy, bus.done, bus.err});
        end
        n_chk++;
        if ({bus.paddx, bus.paddy, bus.paddz} !== 15'd0) begin
            n_fail++; $display("FAIL rst_addr: got %h required 0", {bus.paddx, bus.paddy, bus.paddz});
        end
        n_chk++;
        if (bus.phase !== 2'b00) begin n_fail++; $display("FAIL rst_phase: got %b required 00", bus.phase); end
        n_chk++;
        if ({bus.dbl_cnt, bus.add_cnt} !== 32'd0) begin
            n_fail++; $display("FAIL rst_cnt: got %0d/%0d required 0/0", bus.dbl_cnt, bus.add_cnt);
        end
        rst = 1'b1;
        tick(2);
        n_chk++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b required 0", bus.busy); end
    endtask

    task automatic test_main_run();
        int r0 = rdy_n, l0 = ld_n, d0 = dbl_n, a0 = add_n, c0 = conv_n, n0 = done_n, p0 = pre_n;
        pulse_start();
        feed(4'h0, 1'b0); feed(4'h0, 1'b0); feed(4'h3, 1'b0); feed(4'h0, 1'b0); feed(4'hF, 1'b1);
        wait_end("main");
        tick(2);
        n_chk++; if (pre_n - p0 !== 1 || pre_ph !== 2'b00) begin n_fail++; $display("FAIL main_pre: got %0d ph %b required 1 ph 00", pre_n - p0, pre_ph); end
        n_chk++; if (dbl_at_ld - d0 !== 0) begin n_fail++; $display("FAIL main_lead_zero_dbl: got %0d required 0", dbl_at_ld - d0); end
        n_chk++; if (ld_n - l0 !== 1) begin n_fail++; $display("FAIL main_ld_cnt: got %0d required 1", ld_n - l0); end
        n_chk++; if ({ld_x, ld_y, ld_z, ld_s, ld_aff} !== {5'd2, 5'd3, 5'd4, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL main_ld_addr: got %0d,%0d,%0d s%b a%b required 2,3,4 s0 a0", ld_x, ld_y, ld_z, ld_s, ld_aff); end
        n_chk++; if (ld_ph !== 2'b10) begin n_fail++; $display("FAIL main_ld_phase: got %b required 10", ld_ph); end
        n_chk++; if (dbl_n - d0 !== 2 || dbl_ph !== 2'b01) begin n_fail++; $display("FAIL main_dbl: got %0d ph %b required 2 ph 01", dbl_n - d0, dbl_ph); end
        n_chk++; if (add_n - a0 !== 1) begin n_fail++; $display("FAIL main_add_cnt: got %0d required 1", add_n - a0); end
        n_chk++; if ({add_x, add_y, add_z, add_s} !== {5'd8, 5'd9, 5'd10, 1'b1}) begin
            n_fail++; $display("FAIL main_add_addr: got %0d,%0d,%0d s%b required 8,9,10 s1", add_x, add_y, add_z, add_s); end
        n_chk++; if (conv_n - c0 !== 1 || conv_ph !== 2'b11) begin n_fail++; $display("FAIL main_conv: got %0d ph %b required 1 ph 11", conv_n - c0, conv_ph); end
        n_chk++; if (done_n - n0 !== 1 || done_inf !== 1'b0) begin n_fail++; $display("FAIL main_done: got %0d inf %b required 1 inf 0", done_n - n0, done_inf); end
        n_chk++; if (rdy_n - r0 !== 5) begin n_fail++; $display("FAIL main_rdy: got %0d required 5", rdy_n - r0); end
        n_chk++; if (bus.dbl_cnt !== CNT_W'(STAT ? 2 : 0) || bus.add_cnt !== CNT_W'(STAT ? 1 : 0)) begin
            n_fail++; $display("FAIL main_stat: got %0d/%0d required %0d/%0d", bus.dbl_cnt, bus.add_cnt, STAT ? 2 : 0, STAT ? 1 : 0); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL main_idle: busy got %b required 0", bus.busy); end
    endtask

    task automatic test_all_zero();
        int l0 = ld_n, d0 = dbl_n, a0 = add_n, c0 = conv_n, n0 = done_n;
        pulse_start();
        feed(4'h0, 1'b0); feed(4'h0, 1'b0); feed(4'h0, 1'b1);
        wait_end("zero");
        tick(2);
        n_chk++; if ((ld_n - l0) + (dbl_n - d0) + (add_n - a0) + (conv_n - c0) !== 0) begin
            n_fail++; $display("FAIL zero_ops: got %0d ld/dbl/add/conv required 0", (ld_n - l0) + (dbl_n - d0) + (add_n - a0) + (conv_n - c0)); end
        n_chk++; if (done_n - n0 !== 1 || done_inf !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0d inf %b required 1 inf 1", done_n - n0, done_inf); end
        n_chk++; if ({bus.dbl_cnt, bus.add_cnt} !== 32'd0) begin n_fail++; $display("FAIL zero_stat: got %0d/%0d required 0/0", bus.dbl_cnt, bus.add_cnt); end
    endtask

    task automatic test_affine();
        int d0 = dbl_n, c0 = conv_n, n0 = done_n;
        pulse_start();
        feed(4'h1, 1'b0); feed(4'h5, 1'b1);
        wait_end("aff");
        tick(2);
        n_chk++; if ({ld_x, ld_y, ld_z, ld_aff} !== {5'd0, 5'd1, 5'd19, 1'b1}) begin
            n_fail++; $display("FAIL aff_ld_addr: got %0d,%0d,%0d a%b required 0,1,19 a1", ld_x, ld_y, ld_z, ld_aff); end
        n_chk++; if ({add_x, add_y, add_z, add_aff, add_s} !== {5'd5, 5'd6, 5'd7, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL aff_add_addr: got %0d,%0d,%0d a%b s%b required 5,6,7 a0 s0", add_x, add_y, add_z, add_aff, add_s); end
        n_chk++; if (dbl_n - d0 !== 1 || conv_n - c0 !== 1 || done_n - n0 !== 1) begin
            n_fail++; $display("FAIL aff_seq: got dbl %0d conv %0d done %0d required 1 1 1", dbl_n - d0, conv_n - c0, done_n - n0); end
    endtask

    task automatic test_illegal();
        int n0 = done_n, e0 = err_n;
        pulse_start();
        feed(4'h3, 1'b0); feed(4'h4, 1'b0);
        n_chk++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL ill_err: got err %b busy %b required err 1 busy 0", bus.err, bus.busy); end
        tick(1);
        n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ill_err_width: got %b required 0", bus.err); end
        tick(5);
        n_chk++; if (done_n - n0 !== 0 || err_n - e0 !== 1) begin
            n_fail++; $display("FAIL ill_count: got done %0d err %0d required 0 1", done_n - n0, err_n - e0); end
    endtask

    task automatic test_abort();
        int d0 = dbl_n, a0 = add_n, n0 = done_n, e0 = err_n;
        pulse_start();
        feed(4'h3, 1'b0); feed(4'h0, 1'b0);
        eng_auto = 1'b0;
        tick(1);
        bus.abort = 1'b1; tick(1); bus.abort = 1'b0;
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy got %b required 0", bus.busy); end
        man_v[2] = 1'b1; tick(1); man_v[2] = 1'b0;
        tick(4);
        n_chk++; if (bus.busy !== 1'b0 || done_n - n0 !== 0 || err_n - e0 !== 0) begin
            n_fail++; $display("FAIL abort_late_end: busy %b done %0d err %0d required 0 0 0", bus.busy, done_n - n0, err_n - e0); end
        n_chk++; if (dbl_n - d0 !== 1 || add_n - a0 !== 0) begin
            n_fail++; $display("FAIL abort_no_en: dbl %0d add %0d required 1 0", dbl_n - d0, add_n - a0); end
        eng_auto = 1'b1;
        n0 = done_n;
        pulse_start();
        feed(4'h3, 1'b0); feed(4'h1, 1'b1);
        wait_end("abort_rerun");
        tick(2);
        n_chk++; if (done_n - n0 !== 1 || done_inf !== 1'b0 || {add_x, add_z, add_aff} !== {5'd0, 5'd19, 1'b1}) begin
            n_fail++; $display("FAIL abort_rerun: done %0d inf %b addx %0d addz %0d aff %b required 1 0 0 19 1", done_n - n0, done_inf, add_x, add_z, add_aff); end
        n_chk++; if (bus.dbl_cnt !== CNT_W'(STAT ? 1 : 0) || bus.add_cnt !== CNT_W'(STAT ? 1 : 0)) begin
            n_fail++; $display("FAIL abort_rerun_stat: got %0d/%0d required %0d/%0d", bus.dbl_cnt, bus.add_cnt, STAT ? 1 : 0, STAT ? 1 : 0); end
    endtask

    task automatic test_rst_mid_add();
        bit seen = 0;
        int p0, a0, c0, n0;
        pulse_start();
        feed(4'h3, 1'b0); feed(4'h5, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.add_en) begin seen = 1; break; end
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL rmid_add_wait: add_en 0, required 1 within 100 cycles"); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if ({bus.add_en, bus.busy, bus.phase, bus.psign, bus.paffine, bus.done, bus.naf_rdy} !== 8'd0) begin
            n_fail++; $display("FAIL rmid_flags: got %b required 0", {bus.add_en, bus.busy, bus.phase}); end
        n_chk++; if ({bus.paddx, bus.paddy, bus.paddz, bus.dbl_cnt, bus.add_cnt} !== 47'd0) begin
            n_fail++; $display("FAIL rmid_addr_cnt: got %0d,%0d,%0d cnt %0d/%0d required 0", bus.paddx, bus.paddy, bus.paddz, bus.dbl_cnt, bus.add_cnt); end
        tick(1);
        rst = 1'b1;
        tick(1);
        p0 = pre_n; a0 = add_n; c0 = conv_n; n0 = done_n;
        pulse_start();
        tick(8);
        pulse_start();
        tick(3);
        n_chk++; if (pre_n - p0 !== 1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_start: pre %0d busy %b required 1 1", pre_n - p0, bus.busy); end
        man_v[3] = 1'b1; tick(1); man_v[3] = 1'b0;
        tick(2);
        n_chk++; if (bus.busy !== 1'b1 || bus.phase !== 2'b00 || add_n - a0 !== 0) begin
            n_fail++; $display("FAIL fetch_add_end: busy %b phase %b add %0d required 1 00 0", bus.busy, bus.phase, add_n - a0); end
        feed(4'h7, 1'b1);
        wait_end("rmid_rerun");
        tick(2);
        n_chk++; if ({ld_x, ld_y, ld_z} !== {5'd8, 5'd9, 5'd10} || conv_n - c0 !== 1 || done_n - n0 !== 1 || done_inf !== 1'b0) begin
            n_fail++; $display("FAIL rmid_rerun: ld %0d,%0d,%0d conv %0d done %0d inf %b required 8,9,10 1 1 0", ld_x, ld_y, ld_z, conv_n - c0, done_n - n0, done_inf); end
    endtask

    initial begin
        rst = 1'b0;
        eng_auto = 1'b1; man_v = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.naf_vld = 1'b0; bus.naf_dig = '0; bus.naf_last = 1'b0;
        tick(3);
        test_reset();
        test_main_run();
        test_all_zero();
        test_affine();
        test_illegal();
        test_abort();
        test_rst_mid_add();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
